// File: rtl/mem_arb_pkg.sv
// Shared types and default parameters for the memory-port arbiter.
package mem_arb_pkg;

    // Arbiter FSM: IDLE accepts a new request, WAIT holds for its response.
    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_WAIT = 1'b1
    } arb_state_e;

    // Which requester owns the outstanding transaction.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } owner_e;

    // Consecutive data grants tolerated while fetch is waiting.
    localparam int STARVE_MAX_DEF = 4;
    // Cycles allowed from grant to the memory response.
    localparam int TIMEOUT_DEF    = 16;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store.
// One outstanding transaction; data has priority except when fetch has
// been starved for STARVE_MAX consecutive data grants. Missing or
// spurious memory responses set a sticky err flag.
//
// Handshake: a requester raises *_req with a stable payload and holds it
// until *_gnt is seen high in a cycle; that cycle is the transfer. The
// response arrives later as a single-cycle *_rvalid pulse with *_rdata.
// On the memory side m_req is a one-cycle command (no ready), and
// m_rvalid is a single-cycle response to the outstanding command.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = STARVE_MAX_DEF,
    parameter int TIMEOUT    = TIMEOUT_DEF
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,

    input  logic                d_req,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_be,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,

    output logic                m_req,
    output logic                m_we,
    output logic [DATA_W/8-1:0] m_be,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [DATA_W-1:0]   m_wdata,
    input  logic                m_rvalid,
    input  logic [DATA_W-1:0]   m_rdata,

    output logic                err
);

    localparam int BE_W = DATA_W / 8;
    localparam int SW   = $clog2(STARVE_MAX + 1);
    localparam int CW   = $clog2(TIMEOUT + 1);

    localparam logic [SW-1:0] STREAK_MAX = SW'(STARVE_MAX);
    localparam logic [CW-1:0] CNT_INIT   = CW'(TIMEOUT);

    arb_state_e      state_q,  state_d;
    owner_e          owner_q,  owner_d;
    logic [SW-1:0]   streak_q, streak_d;
    logic [CW-1:0]   cnt_q,    cnt_d;
    logic            err_q,    err_d;

    logic            fetch_forced;

    // Both sides may see the memory data; only the owner gets rvalid.
    assign if_rdata = m_rdata;
    assign d_rdata  = m_rdata;
    assign err      = err_q;

    // Fetch overrides data only once it has lost STARVE_MAX grants in a row.
    assign fetch_forced = if_req && d_req && (streak_q == STREAK_MAX);

    // Arbitration, memory command mux, response routing and timeout.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        streak_d  = streak_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        if_gnt    = 1'b0;
        d_gnt     = 1'b0;
        if_rvalid = 1'b0;
        d_rvalid  = 1'b0;
        m_req     = 1'b0;
        m_we      = 1'b0;
        m_be      = '0;
        m_addr    = '0;
        m_wdata   = '0;

        case (state_q)
            ARB_IDLE: begin
                // No transaction is outstanding, so any response is a fault.
                if (m_rvalid) begin
                    err_d = 1'b1;
                end
                if (d_req && !fetch_forced) begin
                    d_gnt    = 1'b1;
                    m_req    = 1'b1;
                    m_we     = d_we;
                    m_be     = d_be;
                    m_addr   = d_addr;
                    m_wdata  = d_wdata;
                    owner_d  = OWN_D;
                    state_d  = ARB_WAIT;
                    cnt_d    = CNT_INIT;
                    if (!if_req) begin
                        streak_d = '0;
                    end else if (streak_q != STREAK_MAX) begin
                        streak_d = streak_q + SW'(1);
                    end
                end else if (if_req) begin
                    if_gnt   = 1'b1;
                    m_req    = 1'b1;
                    m_we     = 1'b0;
                    m_be     = {BE_W{1'b1}};
                    m_addr   = if_addr;
                    owner_d  = OWN_IF;
                    state_d  = ARB_WAIT;
                    cnt_d    = CNT_INIT;
                    streak_d = '0;
                end
            end

            ARB_WAIT: begin
                // A response on the last allowed cycle still counts as normal.
                if (m_rvalid) begin
                    if_rvalid = (owner_q == OWN_IF);
                    d_rvalid  = (owner_q == OWN_D);
                    state_d   = ARB_IDLE;
                    owner_d   = OWN_NONE;
                end else if (cnt_q <= CW'(1)) begin
                    err_d   = 1'b1;
                    state_d = ARB_IDLE;
                    owner_d = OWN_NONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end

            default: begin
                state_d = ARB_IDLE;
                owner_d = OWN_NONE;
            end
        endcase

        // While rst is high no handshake may be seen by either side.
        if (rst) begin
            if_gnt    = 1'b0;
            d_gnt     = 1'b0;
            if_rvalid = 1'b0;
            d_rvalid  = 1'b0;
            m_req     = 1'b0;
        end
    end

    // State registers with synchronous reset; reset abandons any transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ARB_IDLE;
            owner_q  <= OWN_NONE;
            streak_q <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            streak_q <= streak_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reset, single fetch, starvation
// order, store, timeout, spurious response and reset during WAIT.
// Inputs change 1ns after the rising edge; outputs are checked on the
// falling edge.
module tb_mem_port_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int BE_W   = DATA_W / 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;
    logic              d_req;
    logic              d_we;
    logic [BE_W-1:0]   d_be;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;
    logic              m_req;
    logic              m_we;
    logic [BE_W-1:0]   m_be;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic              m_rvalid;
    logic [DATA_W-1:0] m_rdata;
    logic              err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .STARVE_MAX (4),
        .TIMEOUT    (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_be      (d_be),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .m_req     (m_req),
        .m_we      (m_we),
        .m_be      (m_be),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_rvalid  (m_rvalid),
        .m_rdata   (m_rdata),
        .err       (err)
    );

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Move to the falling edge where outputs are sampled.
    task automatic settle();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        if_req   = 1'b0;
        if_addr  = '0;
        d_req    = 1'b0;
        d_we     = 1'b0;
        d_be     = '0;
        d_addr   = '0;
        d_wdata  = '0;
        m_rvalid = 1'b0;
        m_rdata  = '0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        if_req = 1'b1;
        d_req = 1'b1;
        m_rvalid = 1'b1;
        settle();
        total++; if (if_gnt !== 1'b0) begin bad++; $display("FAIL reset_if_gnt: got %0b want 0", if_gnt); end
        total++; if (d_gnt !== 1'b0) begin bad++; $display("FAIL reset_d_gnt: got %0b want 0", d_gnt); end
        total++; if (m_req !== 1'b0) begin bad++; $display("FAIL reset_m_req: got %0b want 0", m_req); end
        total++; if ({if_rvalid, d_rvalid} !== 2'b00) begin bad++; $display("FAIL reset_rvalid: got %02b want 00", {if_rvalid, d_rvalid}); end
        tick();
        rst = 1'b0;
        clear_inputs();
        settle();
        total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err: got %0b want 0", err); end
        total++; if (m_req !== 1'b0) begin bad++; $display("FAIL reset_idle_m_req: got %0b want 0", m_req); end
        tick();
    endtask

    task automatic test_fetch();
        if_req = 1'b1;
        if_addr = 32'h0000_0000;
        settle();
        total++; if (if_gnt !== 1'b1) begin bad++; $display("FAIL fetch_gnt: got %0b want 1", if_gnt); end
        total++; if (d_gnt !== 1'b0) begin bad++; $display("FAIL fetch_d_gnt: got %0b want 0", d_gnt); end
        total++; if (m_req !== 1'b1) begin bad++; $display("FAIL fetch_m_req: got %0b want 1", m_req); end
        total++; if (m_addr !== 32'h0) begin bad++; $display("FAIL fetch_m_addr: got %08h want 00000000", m_addr); end
        total++; if (m_we !== 1'b0) begin bad++; $display("FAIL fetch_m_we: got %0b want 0", m_we); end
        total++; if (m_be !== 4'hF) begin bad++; $display("FAIL fetch_m_be: got %0h want f", m_be); end
        tick();
        if_req = 1'b0;
        m_rvalid = 1'b1;
        m_rdata = 32'h0000_0013;
        settle();
        total++; if (if_rvalid !== 1'b1) begin bad++; $display("FAIL fetch_rvalid: got %0b want 1", if_rvalid); end
        total++; if (if_rdata !== 32'h0000_0013) begin bad++; $display("FAIL fetch_rdata: got %08h want 00000013", if_rdata); end
        total++; if (d_rvalid !== 1'b0) begin bad++; $display("FAIL fetch_d_rvalid: got %0b want 0", d_rvalid); end
        total++; if (m_req !== 1'b0) begin bad++; $display("FAIL fetch_wait_m_req: got %0b want 0", m_req); end
        tick();
        m_rvalid = 1'b0;
        if_req = 1'b1;
        if_addr = 32'h0000_0004;
        settle();
        total++; if (if_gnt !== 1'b1) begin bad++; $display("FAIL fetch_next_gnt: got %0b want 1", if_gnt); end
        total++; if (m_addr !== 32'h4) begin bad++; $display("FAIL fetch_next_addr: got %08h want 00000004", m_addr); end
        tick();
        if_req = 1'b0;
        m_rvalid = 1'b1;
        m_rdata = 32'h0010_0093;
        settle();
        total++; if (if_rvalid !== 1'b1) begin bad++; $display("FAIL fetch_next_rvalid: got %0b want 1", if_rvalid); end
        tick();
        clear_inputs();
    endtask

    task automatic test_starvation();
        // Bit i set means transaction i must go to fetch: D,D,D,D,IF,D,D,D,D,IF.
        logic [9:0] pat;
        pat = 10'b10_0001_0000;
        if_req = 1'b1;
        if_addr = 32'h0000_0040;
        d_req = 1'b1;
        d_we = 1'b0;
        d_be = 4'hF;
        d_addr = 32'h0000_2000;
        for (int i = 0; i < 10; i++) begin
            settle();
            total++; if (if_gnt !== pat[i]) begin bad++; $display("FAIL starve_if_gnt[%0d]: got %0b want %0b", i, if_gnt, pat[i]); end
            total++; if (d_gnt !== ~pat[i]) begin bad++; $display("FAIL starve_d_gnt[%0d]: got %0b want %0b", i, d_gnt, ~pat[i]); end
            total++; if (m_addr !== (pat[i] ? 32'h40 : 32'h2000)) begin bad++; $display("FAIL starve_m_addr[%0d]: got %08h want %08h", i, m_addr, (pat[i] ? 32'h40 : 32'h2000)); end
            tick();
            m_rvalid = 1'b1;
            m_rdata = 32'h1000 + i;
            settle();
            total++; if (m_req !== 1'b0) begin bad++; $display("FAIL starve_wait_m_req[%0d]: got %0b want 0", i, m_req); end
            total++; if ({if_rvalid, d_rvalid} !== {pat[i], ~pat[i]}) begin bad++; $display("FAIL starve_rvalid[%0d]: got %02b want %02b", i, {if_rvalid, d_rvalid}, {pat[i], ~pat[i]}); end
            tick();
            m_rvalid = 1'b0;
        end
        clear_inputs();
    endtask

    task automatic test_store();
        d_req = 1'b1;
        d_we = 1'b1;
        d_be = 4'b0011;
        d_addr = 32'h0000_2004;
        d_wdata = 32'hDEAD_BEEF;
        settle();
        total++; if (d_gnt !== 1'b1) begin bad++; $display("FAIL store_gnt: got %0b want 1", d_gnt); end
        total++; if (m_we !== 1'b1) begin bad++; $display("FAIL store_m_we: got %0b want 1", m_we); end
        total++; if (m_be !== 4'b0011) begin bad++; $display("FAIL store_m_be: got %04b want 0011", m_be); end
        total++; if (m_addr !== 32'h2004) begin bad++; $display("FAIL store_m_addr: got %08h want 00002004", m_addr); end
        total++; if (m_wdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL store_m_wdata: got %08h want deadbeef", m_wdata); end
        tick();
        clear_inputs();
        m_rvalid = 1'b1;
        settle();
        total++; if (d_rvalid !== 1'b1) begin bad++; $display("FAIL store_ack: got %0b want 1", d_rvalid); end
        total++; if (if_rvalid !== 1'b0) begin bad++; $display("FAIL store_if_rvalid: got %0b want 0", if_rvalid); end
        tick();
        clear_inputs();
    endtask

    task automatic test_timeout();
        d_req = 1'b1;
        d_be = 4'hF;
        d_addr = 32'h0000_3000;
        settle();
        total++; if (d_gnt !== 1'b1) begin bad++; $display("FAIL timeout_gnt: got %0b want 1", d_gnt); end
        tick();
        d_req = 1'b0;
        if_req = 1'b1;
        if_addr = 32'h0000_0100;
        // Cycles 1..16 after the grant: still waiting, err not yet visible.
        for (int c = 1; c <= 16; c++) begin
            settle();
            total++; if (if_gnt !== 1'b0) begin bad++; $display("FAIL timeout_wait_gnt[%0d]: got %0b want 0", c, if_gnt); end
            total++; if (err !== 1'b0) begin bad++; $display("FAIL timeout_early_err[%0d]: got %0b want 0", c, err); end
            total++; if (d_rvalid !== 1'b0) begin bad++; $display("FAIL timeout_d_rvalid[%0d]: got %0b want 0", c, d_rvalid); end
            tick();
        end
        settle();
        total++; if (err !== 1'b1) begin bad++; $display("FAIL timeout_err: got %0b want 1", err); end
        total++; if (if_gnt !== 1'b1) begin bad++; $display("FAIL timeout_next_gnt: got %0b want 1", if_gnt); end
        total++; if (m_addr !== 32'h100) begin bad++; $display("FAIL timeout_next_addr: got %08h want 00000100", m_addr); end
        tick();
        if_req = 1'b0;
        m_rvalid = 1'b1;
        m_rdata = 32'h0000_00AA;
        settle();
        total++; if ({if_rvalid, d_rvalid} !== 2'b10) begin bad++; $display("FAIL timeout_next_rvalid: got %02b want 10", {if_rvalid, d_rvalid}); end
        tick();
        clear_inputs();
    endtask

    task automatic test_spurious();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        settle();
        total++; if (err !== 1'b0) begin bad++; $display("FAIL spurious_pre_err: got %0b want 0", err); end
        tick();
        m_rvalid = 1'b1;
        m_rdata = 32'h5555_5555;
        settle();
        total++; if ({if_rvalid, d_rvalid} !== 2'b00) begin bad++; $display("FAIL spurious_rvalid: got %02b want 00", {if_rvalid, d_rvalid}); end
        tick();
        m_rvalid = 1'b0;
        settle();
        total++; if (err !== 1'b1) begin bad++; $display("FAIL spurious_err: got %0b want 1", err); end
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        settle();
        total++; if (err !== 1'b0) begin bad++; $display("FAIL spurious_clear: got %0b want 0", err); end
        tick();
    endtask

    task automatic test_reset_in_wait();
        // Build a streak of 3 data grants, then reset in the third WAIT.
        if_req = 1'b1;
        if_addr = 32'h0000_0080;
        d_req = 1'b1;
        d_be = 4'hF;
        d_addr = 32'h0000_2000;
        for (int i = 0; i < 3; i++) begin
            settle();
            total++; if (d_gnt !== 1'b1) begin bad++; $display("FAIL rstwait_pre_gnt[%0d]: got %0b want 1", i, d_gnt); end
            tick();
            if (i < 2) begin
                m_rvalid = 1'b1;
                tick();
                m_rvalid = 1'b0;
            end
        end
        rst = 1'b1;
        m_rvalid = 1'b1;
        settle();
        total++; if ({if_rvalid, d_rvalid} !== 2'b00) begin bad++; $display("FAIL rstwait_rvalid: got %02b want 00", {if_rvalid, d_rvalid}); end
        total++; if ({if_gnt, d_gnt, m_req} !== 3'b000) begin bad++; $display("FAIL rstwait_gnt: got %03b want 000", {if_gnt, d_gnt, m_req}); end
        tick();
        rst = 1'b0;
        m_rvalid = 1'b0;
        // A cleared streak means four data grants again before fetch.
        for (int j = 0; j < 5; j++) begin
            settle();
            total++; if ({if_gnt, d_gnt} !== ((j == 4) ? 2'b10 : 2'b01)) begin bad++; $display("FAIL rstwait_order[%0d]: got %02b want %02b", j, {if_gnt, d_gnt}, ((j == 4) ? 2'b10 : 2'b01)); end
            tick();
            m_rvalid = 1'b1;
            tick();
            m_rvalid = 1'b0;
        end
        // Reset during a fetch WAIT with fetch still pending afterwards.
        d_req = 1'b0;
        settle();
        total++; if (if_gnt !== 1'b1) begin bad++; $display("FAIL rstwait_fetch_gnt: got %0b want 1", if_gnt); end
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        if_addr = 32'h0000_0200;
        settle();
        total++; if (if_gnt !== 1'b1) begin bad++; $display("FAIL rstwait_regrant: got %0b want 1", if_gnt); end
        total++; if (m_addr !== 32'h200) begin bad++; $display("FAIL rstwait_regrant_addr: got %08h want 00000200", m_addr); end
        total++; if (if_rvalid !== 1'b0) begin bad++; $display("FAIL rstwait_stale: got %0b want 0", if_rvalid); end
        tick();
        if_req = 1'b0;
        settle();
        total++; if (if_rvalid !== 1'b0) begin bad++; $display("FAIL rstwait_no_rvalid: got %0b want 0", if_rvalid); end
        tick();
        m_rvalid = 1'b1;
        m_rdata = 32'h0000_0BEE;
        settle();
        total++; if (if_rvalid !== 1'b1) begin bad++; $display("FAIL rstwait_rvalid_final: got %0b want 1", if_rvalid); end
        total++; if (if_rdata !== 32'h0000_0BEE) begin bad++; $display("FAIL rstwait_rdata_final: got %08h want 00000bee", if_rdata); end
        tick();
        clear_inputs();
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        tick();
        test_reset();
        test_fetch();
        test_starvation();
        test_store();
        test_timeout();
        test_spurious();
        test_reset_in_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Guard against a stalled run.
    initial begin
        #200000;
        bad++;
        $display("FAIL watchdog: simulation did not finish within 200000 time units");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
